// File: rtl/alu_issue_ctrl.sv
// Single-issue controller for a combinational ALU: reads two operands from a small
// register file, feeds the ALU for one cycle, then writes the result back.
module alu_issue_ctrl #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_in0,
  output logic [DATA_W-1:0] alu_in1,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [2:0]        res_rd,
  input  logic              ld_en,
  input  logic [2:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] regs [NREGS];
  logic [2:0]        rd_q;
  logic              accept;
  logic [2:0]        f_op;
  logic [2:0]        f_rd;
  logic [2:0]        f_rs0;
  logic [2:0]        f_rs1;
  logic [DATA_W-1:0] rd0_val;
  logic [DATA_W-1:0] rd1_val;

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; instr_ready never depends on instr_valid, and an
  // instruction offered while instr_ready is low is dropped, not queued.
  assign instr_ready = (state_q == IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;

  assign f_op  = instr[15:13];
  assign f_rd  = instr[12:10];
  assign f_rs0 = instr[9:7];
  assign f_rs1 = instr[6:4];

  // R0 is hardwired to zero on the read side; its storage is never written.
  assign rd0_val = (f_rs0 == 3'd0) ? '0 : regs[f_rs0];
  assign rd1_val = (f_rs1 == 3'd0) ? '0 : regs[f_rs1];

  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      alu_op    <= '0;
      alu_in0   <= '0;
      alu_in1   <= '0;
      rd_q      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state_q   <= state_d;
      res_valid <= 1'b0;
      if (accept) begin
        alu_op  <= f_op;
        alu_in0 <= rd0_val;
        alu_in1 <= rd1_val;
        rd_q    <= f_rd;
      end
      if (ld_en && (ld_addr != 3'd0)) regs[ld_addr] <= ld_data;
      // Writeback is assigned after the preload so it wins on a same-register collision.
      if (state_q == EXEC) begin
        res_valid <= 1'b1;
        res_data  <= alu_out;
        res_rd    <= rd_q;
        if (rd_q != 3'd0) regs[rd_q] <= alu_out;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: the bench plays the ALU by driving alu_out
// during the execute cycle and checks operands, writeback and timing.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  alu_op;
  logic [15:0] alu_in0;
  logic [15:0] alu_in1;
  logic [15:0] alu_out;
  logic        res_valid;
  logic [15:0] res_data;
  logic [2:0]  res_rd;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  alu_issue_ctrl #(.DATA_W(16), .NREGS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_op      (alu_op),
    .alu_in0     (alu_in0),
    .alu_in1     (alu_in1),
    .alu_out     (alu_out),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_rd      (res_rd),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_en   = 1'b0;
  endtask

  // One full instruction: accept, execute (optionally with a colliding preload), writeback.
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs0,
                       input logic [2:0] rs1, input logic [15:0] aout,
                       input logic [15:0] exp_in0, input logic [15:0] exp_in1,
                       input logic ld_in_exec, input logic [15:0] ld_d);
    check("ready_before_issue", instr_ready, 1);
    instr       = {op, rd, rs0, rs1, 4'h0};
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    check("exec_alu_op", alu_op, op);
    check("exec_alu_in0", alu_in0, exp_in0);
    check("exec_alu_in1", alu_in1, exp_in1);
    check("exec_res_valid", res_valid, 0);
    check("exec_ready", instr_ready, 0);
    alu_out = aout;
    if (ld_in_exec) begin
      ld_en   = 1'b1;
      ld_addr = rd;
      ld_data = ld_d;
    end
    step();
    ld_en = 1'b0;
    check("wb_res_valid", res_valid, 1);
    check("wb_res_data", res_data, aout);
    check("wb_res_rd", res_rd, rd);
    check("wb_ready", instr_ready, 0);
    step();
    check("post_res_valid", res_valid, 0);
    check("post_res_data_hold", res_data, aout);
    check("post_alu_in0_hold", alu_in0, exp_in0);
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    alu_out     = '0;
    ld_en       = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;

    // Reset held for two edges
    step();
    check("rst_ready_low", instr_ready, 0);
    step();
    check("rst_ready_low2", instr_ready, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_in0", alu_in0, 0);
    check("rst_alu_in1", alu_in1, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_rd", res_rd, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", instr_ready, 1);
    check("state_after_rst", dbg_state, 0);

    // Basic issue and dependent read of the result
    preload(3'd1, 16'h2543);
    preload(3'd2, 16'h1234);
    issue(3'b110, 3'd3, 3'd1, 3'd2, 16'hBEEF, 16'h2543, 16'h1234, 1'b0, 16'h0);
    issue(3'b000, 3'd5, 3'd3, 3'd1, 16'h1111, 16'hBEEF, 16'h2543, 1'b0, 16'h0);

    // R0: writeback and preload are discarded, result still reported
    issue(3'b001, 3'd0, 3'd1, 3'd2, 16'h00FF, 16'h2543, 16'h1234, 1'b0, 16'h0);
    preload(3'd0, 16'h7777);
    issue(3'b010, 3'd6, 3'd0, 3'd5, 16'h0001, 16'h0000, 16'h1111, 1'b0, 16'h0);

    // instr_valid held six cycles: accepts at 0 and 3, results at 2 and 5
    begin
      int n_acc = 0;
      int n_res = 0;
      instr       = {3'b011, 3'd6, 3'd1, 3'd2, 4'h0};
      instr_valid = 1'b1;
      alu_out     = 16'h3333;
      for (int i = 0; i < 6; i++) begin
        check("burst_ready", instr_ready, (i % 3 == 0) ? 1 : 0);
        check("burst_res_valid", res_valid, (i % 3 == 2) ? 1 : 0);
        if (i % 3 == 1) check("burst_alu_in0", alu_in0, 16'h2543);
        if (instr_ready) n_acc++;
        if (res_valid) n_res++;
        step();
      end
      instr_valid = 1'b0;
      check("burst_accepts", n_acc, 2);
      check("burst_results", n_res, 2);
    end

    // Preload colliding with writeback to R3: writeback wins
    issue(3'b100, 3'd3, 3'd1, 3'd2, 16'hAAAA, 16'h2543, 16'h1234, 1'b1, 16'h5555);
    issue(3'b000, 3'd7, 3'd3, 3'd0, 16'h0002, 16'hAAAA, 16'h0000, 1'b0, 16'h0);

    // Reset during EXEC aborts the instruction
    instr       = {3'b101, 3'd4, 3'd1, 3'd2, 4'h0};
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    check("abort_in_exec", dbg_state, 1);
    rst     = 1'b1;
    alu_out = 16'h9999;
    step();
    rst = 1'b0;
    #1;
    check("abort_res_valid", res_valid, 0);
    check("abort_ready", instr_ready, 1);
    check("abort_state", dbg_state, 0);
    check("abort_res_data", res_data, 0);
    check("abort_alu_op", alu_op, 0);
    check("abort_alu_in0", alu_in0, 0);
    step();
    check("abort_no_late_res", res_valid, 0);
    issue(3'b000, 3'd5, 3'd4, 3'd1, 16'h0003, 16'h0000, 16'h0000, 1'b0, 16'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter DATA_W, 16, operand/result width; SHALL match the ALU in0/in1/out width.
REQ-002 Parameter NREGS, 8, register file depth; SHALL be addressed by 3-bit fields.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 instr_valid  input  1  instruction offered this cycle.
REQ-006 instr_ready  output  1  block can accept an instruction this cycle.
REQ-007 instr  input  16  [15:13]=op, [12:10]=rd, [9:7]=rs0, [6:4]=rs1, [3:0] ignored.
REQ-008 alu_op  output  3  registered opcode to the ALU op port.
REQ-009 alu_in0  output  16  registered operand to the ALU in0 port.
REQ-010 alu_in1  output  16  registered operand to the ALU in1 port.
REQ-011 alu_out  input  16  combinational ALU result.
REQ-012 res_valid  output  1  one-cycle pulse: a result was written back.
REQ-013 res_data  output  16  written-back result.
REQ-014 res_rd  output  3  destination register of res_data.
REQ-015 ld_en  input  1  external register preload strobe.
REQ-016 ld_addr  input  3  preload destination.
REQ-017 ld_data  input  16  preload value.

Function
REQ-018 FSM states IDLE, EXEC, WB; transitions IDLE->EXEC on instr_valid&&instr_ready, EXEC->WB unconditionally, WB->IDLE unconditionally.
REQ-019 instr_ready SHALL be 1 only in IDLE with rst low; 0 in EXEC and WB.
REQ-020 On acceptance edge: alu_op<=op, alu_in0<=R[rs0], alu_in1<=R[rs1], rd latched.
REQ-021 Operand reads SHALL return the register value before any same-edge write (no preload bypass).
REQ-022 R0 SHALL read as 0; writes to R0 (preload or writeback) SHALL be discarded, but res_valid/res_data/res_rd still reported.
REQ-023 EXEC->WB edge: R[rd]<=alu_out, res_data<=alu_out, res_rd<=rd, res_valid<=1.
REQ-024 res_valid SHALL be high exactly during the WB cycle; 0 otherwise.
REQ-025 Latency: acceptance in cycle N -> ALU inputs valid cycle N+1 -> res_valid cycle N+2 -> instr_ready high again cycle N+3; max throughput 1 instruction / 3 cycles.
REQ-026 alu_op/alu_in0/alu_in1 SHALL hold their values until the next acceptance.
REQ-027 res_data/res_rd SHALL hold after the WB cycle until the next writeback.
REQ-028 ld_en SHALL be honoured in any state; R[ld_addr]<=ld_data on that edge.
REQ-029 Simultaneous preload and writeback to the same register: writeback SHALL win.
REQ-030 instr_valid while instr_ready=0 SHALL be ignored; no instruction is queued.
REQ-031 Arithmetic is entirely in the ALU; this block SHALL pass alu_out unmodified, 16 bits, no extension.

Reset
REQ-032 rst high on an edge: state<=IDLE, R0..R7<=0, alu_op<=0, alu_in0<=0, alu_in1<=0, res_valid<=0, res_data<=0, res_rd<=0.
REQ-033 rst SHALL take priority over acceptance, preload, and writeback on the same edge.
REQ-034 rst during EXEC or WB SHALL abort the instruction with no register write and no res_valid pulse.
REQ-035 First acceptance possible in the first cycle after rst deasserts.

Verification
REQ-036 Reset: assert rst 2 cycles -> all outputs 0, instr_ready=0 during rst, 1 in the cycle after.
REQ-037 Preload R1=0x2543, R2=0x1234; issue op=110, rd=3, rs0=1, rs1=2; bench drives alu_out=0xBEEF -> cycle N+1 alu_op=110, alu_in0=0x2543, alu_in1=0x1234; cycle N+2 res_valid=1, res_data=0xBEEF, res_rd=3; a following op=000, rs0=3 sees alu_in0=0xBEEF.
REQ-038 Issue with rd=0, alu_out=0x00FF -> res_valid=1, res_data=0x00FF, res_rd=0; a subsequent read of R0 gives alu_in0=0x0000.
REQ-039 Hold instr_valid=1 for 6 consecutive cycles -> exactly 2 acceptances (cycles 0 and 3), 2 res_valid pulses (cycles 2 and 5).
REQ-040 ld_en with ld_addr=3, ld_data=0x5555 on the EXEC->WB edge of an rd=3 writeback with alu_out=0xAAAA -> R3=0xAAAA.
REQ-041 rst pulsed during EXEC of an rd=4 instruction -> no res_valid pulse, R4=0x0000, instr_ready=1 in the cycle after rst drops.
